uart_tx_feeder: RTL and testbench

- Synthesizable 8N1 UART transmitter with a small write FIFO.
- Drives the SoC UART receive pins (RsRx) from a bench-side or FPGA-side source. It is the transmit counterpart of the serial terminal monitor on RsTx.
- Default bit period is 16 HCLK cycles (160 ns at the 100 MHz bench clock), so frames line up with the terminal monitor's 160 ns bit_time.
- Used for loopback and console-input tests on UART0/UART1.

---
 rtl/uart_tx_feeder.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// 8N1 UART transmitter with a small write FIFO, used to drive a SoC RsRx pin.
// Frames go out LSB first; queued bytes are sent back to back with no idle gap.
module uart_tx_feeder #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [7:0]         wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [15:0]      CNT_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;

    logic [1:0]  state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tx_q, tx_d;

    logic push;
    logic pop;
    logic fifo_empty;
    logic cnt_done;

    assign fifo_empty = (level_q == '0);
    assign wr_ready   = (level_q != LEVEL_FULL);
    assign push       = wr_valid & wr_ready;
    assign cnt_done   = (cnt_q == '0);

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) | ~fifo_empty;
    assign fifo_level = level_q;

    // Transmit FSM; pops come only from registered FIFO state, so there is no bypass.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = CNT_RELOAD;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_done) begin
                    cnt_d     = CNT_RELOAD;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_done) begin
                    cnt_d = CNT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        cnt_d   = CNT_RELOAD;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
            2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage needs no reset: entries are only read once the level says they are valid.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: default 16-cycle bits plus a 2-cycle-bit instance.
module tb_uart_tx_feeder;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;

    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    logic [7:0] wr_data2 = 8'h00;
    logic       wr_valid2 = 1'b0;
    logic       wr_ready2;
    logic       tx2;
    logic       busy2;
    logic [2:0] fifo_level2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 HCLK = ~HCLK;

    uart_tx_feeder #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    uart_tx_feeder #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4), .FIFO_AW(2)) dut2 (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .wr_data    (wr_data2),
        .wr_valid   (wr_valid2),
        .wr_ready   (wr_ready2),
        .tx         (tx2),
        .busy       (busy2),
        .fifo_level (fifo_level2)
    );

    // Walks one whole frame starting in the cycle the start bit appears, counting
    // cycles where the line differs from the ideal 8N1 waveform.
    task automatic run_frame(input int which, input logic [7:0] b, output int bad);
        int         cpb;
        logic [9:0] f;
        logic       lv;
        cpb = (which == 0) ? 16 : 2;
        f   = {1'b1, b, 1'b0};
        bad = 0;
        for (int j = 0; j < 10 * cpb; j++) begin
            lv = (which == 0) ? tx : tx2;
            if (lv !== f[j / cpb]) bad++;
            @(posedge HCLK); #1;
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        n_tests++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++;
        if (wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_wr_ready got %b want 1", wr_ready);
        end
        n_tests++;
        if (fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
    endtask

    task automatic test_single();
        int bad;
        @(negedge HCLK);
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        @(posedge HCLK); #1;
        wr_valid = 1'b0;
        n_tests++;
        if (fifo_level !== 3'd1 || tx !== 1'b1) begin
            n_fail++; $display("FAIL single_accept level %0d tx %b want 1 1", fifo_level, tx);
        end
        @(posedge HCLK); #1;
        n_tests++;
        if (tx !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pop tx %b level %0d busy %b want 0 0 1", tx, fifo_level, busy);
        end
        run_frame(0, 8'h55, bad);
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL single_wave bad cycles %0d want 0", bad); end
        n_tests++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++; $display("FAIL single_end busy %b tx %b want 0 1", busy, tx);
        end
    endtask

    task automatic test_pair(input logic [7:0] a, input logic [7:0] b, input string nm);
        int bad;
        @(negedge HCLK);
        wr_valid = 1'b1;
        wr_data  = a;
        @(posedge HCLK); #1;
        wr_data = b;
        n_tests++;
        if (fifo_level !== 3'd1) begin
            n_fail++; $display("FAIL %s_level1 got %0d want 1", nm, fifo_level);
        end
        @(posedge HCLK); #1;
        wr_valid = 1'b0;
        n_tests++;
        if (fifo_level !== 3'd1 || tx !== 1'b0) begin
            n_fail++; $display("FAIL %s_level2 level %0d tx %b want 1 0", nm, fifo_level, tx);
        end
        run_frame(0, a, bad);
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL %s_wave_a bad cycles %0d want 0", nm, bad); end
        n_tests++;
        if (fifo_level !== 3'd0 || tx !== 1'b0) begin
            n_fail++; $display("FAIL %s_gap level %0d tx %b want 0 0", nm, fifo_level, tx);
        end
        run_frame(0, b, bad);
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL %s_wave_b bad cycles %0d want 0", nm, bad); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_end busy %b want 0", nm, busy); end
    endtask

    task automatic test_full();
        int bad_total;
        @(negedge HCLK);
        wr_valid = 1'b1;
        wr_data  = 8'h11;
        @(posedge HCLK); #1;
        wr_data = 8'h22;
        @(posedge HCLK); #1;
        wr_data = 8'h33;
        fork
            begin
                int bad;
                bad_total = 0;
                run_frame(0, 8'h11, bad); bad_total += bad;
                run_frame(0, 8'h22, bad); bad_total += bad;
                run_frame(0, 8'h33, bad); bad_total += bad;
                run_frame(0, 8'h44, bad); bad_total += bad;
                run_frame(0, 8'h55, bad); bad_total += bad;
            end
            begin
                int k;
                @(posedge HCLK); #1;
                wr_data = 8'h44;
                @(posedge HCLK); #1;
                wr_data = 8'h55;
                @(posedge HCLK); #1;
                wr_data = 8'h66;
                n_tests++;
                if (fifo_level !== 3'd4 || wr_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_level level %0d ready %b want 4 0", fifo_level, wr_ready);
                end
                k = 0;
                while (k < 300 && wr_ready !== 1'b1) begin
                    @(posedge HCLK); #1;
                    k++;
                end
                wr_valid = 1'b0;
                n_tests++;
                if (k !== 157 || fifo_level !== 3'd3) begin
                    n_fail++;
                    $display("FAIL full_ready_rise after %0d cycles level %0d want 157 3",
                             k, fifo_level);
                end
            end
        join
        n_tests++;
        if (bad_total !== 0) begin
            n_fail++; $display("FAIL full_stream bad cycles %0d want 0", bad_total);
        end
        n_tests++;
        if (busy !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL full_end busy %b level %0d want 0 0", busy, fifo_level);
        end
    endtask

    task automatic test_mid_reset();
        int lows;
        @(negedge HCLK);
        wr_valid = 1'b1;
        wr_data  = 8'h00;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        wr_valid = 1'b0;
        repeat (40) @(posedge HCLK);
        #1;
        n_tests++;
        if (tx !== 1'b0 || fifo_level !== 3'd1) begin
            n_fail++; $display("FAIL midrst_pre tx %b level %0d want 0 1", tx, fifo_level);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        n_tests++;
        if (tx !== 1'b1 || fifo_level !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async tx %b level %0d busy %b want 1 0 0", tx, fifo_level, busy);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        lows = 0;
        repeat (200) begin
            @(negedge HCLK);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        n_tests++;
        if (lows !== 0) begin n_fail++; $display("FAIL midrst_residual cycles %0d want 0", lows); end
        @(posedge HCLK); #1;
    endtask

    task automatic test_cpb2();
        int bad;
        @(negedge HCLK);
        wr_valid2 = 1'b1;
        wr_data2  = 8'hA5;
        @(posedge HCLK); #1;
        wr_data2 = 8'h3C;
        @(posedge HCLK); #1;
        wr_valid2 = 1'b0;
        n_tests++;
        if (tx2 !== 1'b0 || fifo_level2 !== 3'd1) begin
            n_fail++; $display("FAIL cpb2_start tx %b level %0d want 0 1", tx2, fifo_level2);
        end
        run_frame(1, 8'hA5, bad);
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL cpb2_wave_a bad cycles %0d want 0", bad); end
        n_tests++;
        if (tx2 !== 1'b0 || fifo_level2 !== 3'd0) begin
            n_fail++; $display("FAIL cpb2_gap tx %b level %0d want 0 0", tx2, fifo_level2);
        end
        run_frame(1, 8'h3C, bad);
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL cpb2_wave_b bad cycles %0d want 0", bad); end
        n_tests++;
        if (busy2 !== 1'b0 || tx2 !== 1'b1) begin
            n_fail++; $display("FAIL cpb2_end busy %b tx %b want 0 1", busy2, tx2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        repeat (3) @(posedge HCLK);
        #1;
        test_pair(8'h48, 8'h69, "hi");
        repeat (3) @(posedge HCLK);
        #1;
        test_full();
        repeat (3) @(posedge HCLK);
        #1;
        test_mid_reset();
        test_pair(8'hFF, 8'h00, "ff00");
        repeat (3) @(posedge HCLK);
        #1;
        test_cpb2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
